// File: rtl/zmem_arb_pkg.sv
// zmem_arb shared types: FSM states, grant encoding, byte enables.
package zmem_arb_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_VID,
      GNT_CPU,
      GNT_DMA
   } gnt_e;

   localparam logic [1:0] BE_LO   = 2'b01;
   localparam logic [1:0] BE_HI   = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

   function automatic logic [1:0] cpu_be(input logic a0);
      return a0 ? BE_HI : BE_LO;
   endfunction

endpackage

// File: rtl/zmem_arb_prio.sv
// zmem_arb priority pick with CPU starvation guard.
// DMA leg present only when ZMEM_ARB_DMA_EN is defined.
module zmem_arb_prio
   import zmem_arb_pkg::*;
#(
   parameter int VID_BURST = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pick_i,
   input  logic vid_req_i,
   input  logic cpu_pend_i,
   input  logic dma_req_i,
   output gnt_e gnt_o
);

   localparam int CW = $clog2(VID_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(VID_BURST);

   logic [CW-1:0] starve_q, starve_d;
   logic          guard;

`ifndef ZMEM_ARB_DMA_EN
   logic unused_dma;
   assign unused_dma = dma_req_i;
`endif

   assign guard = cpu_pend_i && (starve_q == CNT_MAX);

   always_comb begin
      gnt_o = GNT_NONE;
      if (pick_i) begin
         if (vid_req_i && !guard) begin
            gnt_o = GNT_VID;
         end else if (cpu_pend_i) begin
            gnt_o = GNT_CPU;
`ifdef ZMEM_ARB_DMA_EN
         end else if (dma_req_i) begin
            gnt_o = GNT_DMA;
`endif
         end
      end
   end

   // Only video grants made over a waiting CPU count.
   always_comb begin
      starve_d = starve_q;
      if (gnt_o == GNT_CPU) begin
         starve_d = '0;
      end else if (gnt_o == GNT_VID && cpu_pend_i &&
                   starve_q != CNT_MAX) begin
         starve_d = starve_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end

endmodule

// File: rtl/zmem_arb.sv
// zmem_arb: video/CPU/DMA arbiter for the shared 16-bit memory port.
// Optional DMA port enabled by defining ZMEM_ARB_DMA_EN.
module zmem_arb
   import zmem_arb_pkg::*;
#(
   parameter int AW        = 22,
   parameter int VID_BURST = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          cpu_req_i,
   input  logic          cpu_we_i,
   input  logic [AW-1:0] cpu_addr_i,
   input  logic [7:0]    cpu_wdata_i,
   output logic          cpu_wait_o,
   output logic          cpu_strobe_o,
   output logic [7:0]    cpu_rdata_o,
   input  logic          vid_req_i,
   input  logic [AW-2:0] vid_addr_i,
   output logic          vid_ack_o,
   input  logic          dma_req_i,
   input  logic          dma_we_i,
   input  logic [AW-2:0] dma_addr_i,
   input  logic [15:0]   dma_wdata_i,
   output logic          dma_ack_o,
   output logic [15:0]   rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-2:0] mem_addr_o,
   output logic [1:0]    mem_be_o,
   output logic [15:0]   mem_wdata_o,
   input  logic [15:0]   mem_rdata_i,
   input  logic          mem_done_i
);

   state_e state_q, state_d;
   gnt_e   gnt_q, gnt_d, pick_gnt;

   logic          cpu_pend_q, cpu_we_q;
   logic [AW-1:0] cpu_addr_q;
   logic [7:0]    cpu_wdata_q;

   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-2:0] mem_addr_q, mem_addr_d;
   logic [1:0]    mem_be_q, mem_be_d;
   logic [15:0]   mem_wdata_q, mem_wdata_d;
   logic          vid_ack_q, vid_ack_d;
   logic          dma_ack_q, dma_ack_d;
   logic          cpu_stb_q, cpu_stb_d;
   logic [7:0]    cpu_rdata_q, cpu_rdata_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          pend_eff;

`ifndef ZMEM_ARB_DMA_EN
   logic unused_dma;
   assign unused_dma = ^{dma_we_i, dma_addr_i, dma_wdata_i};
`endif

   // cpu_pend stays up through the strobe cycle; mask it so the
   // finished access is not granted a second time.
   assign pend_eff = cpu_pend_q & ~cpu_stb_q;

   zmem_arb_prio #(.VID_BURST(VID_BURST)) u_prio (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pick_i     (state_q == ST_IDLE),
      .vid_req_i  (vid_req_i),
      .cpu_pend_i (pend_eff),
      .dma_req_i  (dma_req_i),
      .gnt_o      (pick_gnt)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cpu_pend_q  <= 1'b0;
         cpu_we_q    <= 1'b0;
         cpu_addr_q  <= '0;
         cpu_wdata_q <= '0;
      end else if (cpu_stb_q) begin
         cpu_pend_q <= 1'b0;
      end else if (cpu_req_i && !cpu_pend_q) begin
         cpu_pend_q  <= 1'b1;
         cpu_we_q    <= cpu_we_i;
         cpu_addr_q  <= cpu_addr_i;
         cpu_wdata_q <= cpu_wdata_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      vid_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_stb_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      rdata_d     = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (pick_gnt != GNT_NONE) begin
               state_d   = ST_BUSY;
               gnt_d     = pick_gnt;
               mem_req_d = 1'b1;
            end
            unique case (pick_gnt)
               GNT_VID: begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = vid_addr_i;
                  mem_be_d   = BE_WORD;
               end
               GNT_CPU: begin
                  mem_we_d    = cpu_we_q;
                  mem_addr_d  = cpu_addr_q[AW-1:1];
                  mem_be_d    = cpu_be(cpu_addr_q[0]);
                  mem_wdata_d = {cpu_wdata_q, cpu_wdata_q};
               end
`ifdef ZMEM_ARB_DMA_EN
               GNT_DMA: begin
                  mem_we_d    = dma_we_i;
                  mem_addr_d  = dma_addr_i;
                  mem_be_d    = BE_WORD;
                  mem_wdata_d = dma_wdata_i;
               end
`endif
               default: ;
            endcase
         end
         ST_BUSY: begin
            if (mem_done_i) begin
               state_d   = ST_IDLE;
               gnt_d     = GNT_NONE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               unique case (gnt_q)
                  GNT_VID: begin
                     vid_ack_d = 1'b1;
                     rdata_d   = mem_rdata_i;
                  end
                  GNT_CPU: begin
                     cpu_stb_d = 1'b1;
                     if (!cpu_we_q) begin
                        cpu_rdata_d = cpu_addr_q[0] ?
                           mem_rdata_i[15:8] : mem_rdata_i[7:0];
                     end
                  end
`ifdef ZMEM_ARB_DMA_EN
                  GNT_DMA: begin
                     dma_ack_d = 1'b1;
                     if (!mem_we_q) rdata_d = mem_rdata_i;
                  end
`endif
                  default: ;
               endcase
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         gnt_q       <= GNT_NONE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         vid_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_stb_q   <= 1'b0;
         cpu_rdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         vid_ack_q   <= vid_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_stb_q   <= cpu_stb_d;
         cpu_rdata_q <= cpu_rdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign cpu_wait_o   = cpu_pend_q;
   assign cpu_strobe_o = cpu_stb_q;
   assign cpu_rdata_o  = cpu_rdata_q;
   assign vid_ack_o    = vid_ack_q;
   assign dma_ack_o    = dma_ack_q;
   assign rdata_o      = rdata_q;
   assign mem_req_o    = mem_req_q;
   assign mem_we_o     = mem_we_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_be_o     = mem_be_q;
   assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: doc/zmem_arb.md
# zmem_arb

Arbiter sharing the single 16-bit memory port between video refill, Z80 memory cycles and DMA. Video has the highest priority, the CPU second and DMA lowest, with a starvation guard that bounds CPU latency under sustained video load. CPU requests are the one-cycle memory strobes from the Z80 signal decoder. Stalls are reported back to the CPU as `cpu_wait`, which drives the WAIT logic.

## Interface
- `AW`, default 22: CPU byte-address width. Memory word address is `AW-1` bits.
- `VID_BURST`, default 4: maximum consecutive video grants while a CPU request is pending.

Ports:
- `clk` in 1: FPGA clock; the only clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cpu_req` in 1: one-cycle strobe (`memrd_s | memwr_s`).
- `cpu_we` in 1: write when high; sampled with `cpu_req`.
- `cpu_addr` in AW: byte address; sampled with `cpu_req`.
- `cpu_wdata` in 8: sampled with `cpu_req`.
- `cpu_wait` out 1: high while the CPU access is pending.
- `cpu_strobe` out 1: one-cycle completion pulse.
- `cpu_rdata` out 8: read byte; valid with `cpu_strobe`, held after.
- `vid_req` in 1: level request.
- `vid_addr` in AW-1: word address.
- `vid_ack` out 1: one-cycle completion pulse.
- `dma_req` in 1: level request.
- `dma_we` in 1: write when high.
- `dma_addr` in AW-1: word address.
- `dma_wdata` in 16: write data.
- `dma_ack` out 1: one-cycle completion pulse.
- `rdata` out 16: read word for video and DMA; valid with the ack, held after.
- `mem_req` out 1: memory request.
- `mem_we` out 1: memory write enable.
- `mem_addr` out AW-1: memory word address.
- `mem_be` out 2: byte enables.
- `mem_wdata` out 16: memory write data.
- `mem_rdata` in 16: memory read data.
- `mem_done` in 1: one-cycle completion from memory, with read data.

## Operation
- CPU capture: `cpu_req` sets `cpu_pend` and latches `cpu_we`, `cpu_addr` and `cpu_wdata`. `cpu_wait = cpu_pend` (registered, no combinational path from `cpu_req`). `cpu_req` while `cpu_pend` is already set is ignored.
- FSM states:
  - IDLE: pick a requester. If none, stay in IDLE.
  - BUSY: hold the `mem_*` outputs stable until `mem_done`, then go to IDLE.
- Priority in IDLE:
  - Video, unless `cpu_pend` and `starve_cnt == VID_BURST`.
  - Otherwise CPU if `cpu_pend`.
  - Otherwise DMA.
- `starve_cnt` (width `$clog2(VID_BURST+1)`):
  - Increments on each video grant made while `cpu_pend`.
  - Clears on a CPU grant.
  - Saturates at `VID_BURST`.
- CPU byte mapping:
  - `mem_addr = cpu_addr[AW-1:1]`.
  - `mem_be = cpu_addr[0] ? 2'b10 : 2'b01`.
  - `mem_wdata = {cpu_wdata, cpu_wdata}`.
  - `cpu_rdata = cpu_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]`.
- Video and DMA access: `mem_be = 2'b11`. Video is always a read.
- Completion, on `mem_done`:
  - Pulse the ack for the granted requester.
  - For a CPU grant: pulse `cpu_strobe`, clear `cpu_pend`, register the read data.
- Video or DMA dropping `req` mid-access does not abort the access; the ack is still issued.

## Timing
- Reset values: every output 0, state IDLE, `cpu_pend` 0, `starve_cnt` 0. Reset mid-access abandons the access; the memory controller is reset together with this block.
- Latency:
  - Decision in IDLE at cycle N; `mem_req` and `mem_*` valid from N+1.
  - `mem_done` at cycle M gives the ack, `cpu_strobe` and `rdata` at M+1; `mem_req` low at M+1.
  - Earliest next grant decision at M+1; next `mem_req` at M+2.
- Minimum CPU latency: `cpu_req` at cycle 0, `mem_req` at 2, `mem_done` at 2 gives `cpu_strobe` at 3. `cpu_wait` is high for cycles 1..3 and low at 4.
- Simultaneous `cpu_req` and completion of an earlier CPU access: cannot occur, because WAIT holds the Z80. If it does occur, the new request is ignored.
- `mem_done` outside BUSY is ignored.

## Configuration
- `ZMEM_ARB_DMA_EN`:
  - Defined: DMA port arbitrated as above.
  - Undefined: DMA inputs ignored, `dma_ack` tied 0, no DMA mux leg synthesised.

## Structure
- Package `zmem_arb_pkg`:
  - State enum (`ST_IDLE`, `ST_BUSY`).
  - Grant encoding `GNT_NONE`, `GNT_VID`, `GNT_CPU`, `GNT_DMA`.
  - Byte-enable constants.
- Sub-module `zmem_arb_prio`: combinational priority pick plus the `starve_cnt` register. The top level keeps the FSM, CPU capture and datapath muxes.

## Test plan
- CPU read, odd address: `cpu_req` with `cpu_addr=0x00005`, memory returns `0xA55A` → `mem_addr=0x00002`, `mem_be=10`, `cpu_rdata=0xA5`, `cpu_strobe` 1 cycle after `mem_done`, `cpu_wait` low the next cycle.
- CPU write, even address: `cpu_wdata=0x3C`, `cpu_addr=0x00010` → `mem_we=1`, `mem_be=01`, `mem_wdata=0x3C3C`, `mem_addr=0x00008`.
- Starvation guard: `vid_req` held high, CPU request pending, `VID_BURST=4` → exactly 4 `vid_ack`, then one `cpu_strobe`, then video resumes.
- Three-way contention: `vid_req`, `dma_req` and `cpu_req` in the same cycle → grant order video, CPU, DMA; DMA write of `0x1234` lands with `mem_be=11`.
- Reset mid-access: assert `rst` while BUSY with a CPU grant → next cycle all outputs 0 and `cpu_wait` 0; after release, a fresh request is serviced normally.
- DMA disabled (macro undefined): `dma_req` held high → `mem_req` never asserted, `dma_ack` stays 0.
